// File: rtl/dcache_pkg.sv
// Shared types, address-field widths and the halfword helper for the MEM-stage data cache.
// The optional DCACHE_PERF_CNT_EN build adds hit/miss counters to m_stage_dcache.
package dcache_pkg;
  localparam int DATA_W  = 32;
  localparam int PC_W    = 18;
  localparam int INDEX_W = 4;
  localparam int OFF_W   = 2;
  localparam int WORD_W  = 2;
  localparam int TAG_W   = PC_W - INDEX_W - WORD_W - OFF_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

  // Picks the upper (upper=1) or lower halfword and sign-extends it to a full word.
  function automatic logic [DATA_W-1:0] half_sext(input logic [DATA_W-1:0] w, input logic upper);
    logic [DATA_W/2-1:0] h;
    h = upper ? w[DATA_W-1:DATA_W/2] : w[DATA_W/2-1:0];
    return {{(DATA_W/2){h[DATA_W/2-1]}}, h};
  endfunction
endpackage

// File: rtl/m_stage_dcache_if.sv
// Word-memory port between the data cache (master) and the backing memory (slave).
interface m_stage_dcache_if #(parameter int AW = 18, parameter int DW = 32);
  // Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and holds them stable;
  // the slave retires exactly one beat per one-cycle mem_ready pulse (read data valid with it).
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_array.sv
// Tag, valid and 4-word line storage: asynchronous read, synchronous write, async valid clear.
module dcache_array #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 10,
  parameter int DW         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  input  logic [1:0]            rd_word_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DW-1:0]         rd_data_o,
  input  logic                  data_we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [1:0]            wr_word_i,
  input  logic [DW-1:0]         wr_data_i,
  input  logic                  tag_we_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i
);
  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [DW-1:0]       data_q [LINES][4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else if (tag_we_i) valid_q[wr_index_i] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (tag_we_i)  tag_q[wr_index_i] <= wr_tag_i;
    if (data_we_i) data_q[wr_index_i][wr_word_i] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i][rd_word_i];
endmodule

// File: rtl/m_stage_dcache.sv
// Direct-mapped, write-through, no-write-allocate MEM-stage data cache with 4-beat line refill.
// Define DCACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt outputs.
module m_stage_dcache
  import dcache_pkg::*;
#(
  parameter int data_size  = DATA_W,
  parameter int pc_size    = PC_W,
  parameter int INDEX_BITS = INDEX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_Read_enable,
  input  logic                 M_MemWrite,
  input  logic                 M_LH,
  input  logic                 M_SH,
  input  logic [pc_size-1:0]   M_ALU_result,
  input  logic [data_size-1:0] M_Rt_data,
  output logic [data_size-1:0] M_rdata,
  output logic                 dcache_stall,
  m_stage_dcache_if.master     mem,
  output state_t               dbg_state_o
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
`endif
);
  localparam int TB = pc_size - INDEX_BITS - OFF_W - WORD_W;
  localparam int HW = data_size / 2;

  state_t                 state_q;
  logic [1:0]             cnt_q;
  logic                   req_q, we_q;
  logic [pc_size-1:0]     addr_q;
  logic [data_size-1:0]   wdata_q;

  logic [TB-1:0]          a_tag;
  logic [INDEX_BITS-1:0]  a_index;
  logic [1:0]             a_word;
  logic                   a_half;
  logic                   unused_a0;

  logic                   rd_valid;
  logic [TB-1:0]          rd_tag;
  logic [data_size-1:0]   rd_data;
  logic                   hit, is_load, lookup;
  logic [data_size-1:0]   merged;
  logic                   data_we, tag_we;
  logic [1:0]             wr_word;
  logic [data_size-1:0]   wr_data;

  assign a_tag     = M_ALU_result[pc_size-1:INDEX_BITS+4];
  assign a_index   = M_ALU_result[INDEX_BITS+3:4];
  assign a_word    = M_ALU_result[3:2];
  assign a_half    = M_ALU_result[1];
  assign unused_a0 = M_ALU_result[0];

  dcache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TB), .DW(data_size)) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (a_index),
    .rd_word_i  (a_word),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .data_we_i  (data_we),
    .wr_index_i (a_index),
    .wr_word_i  (wr_word),
    .wr_data_i  (wr_data),
    .tag_we_i   (tag_we),
    .wr_tag_i   (a_tag)
  );

  assign hit     = rd_valid && (rd_tag == a_tag);
  assign is_load = M_Read_enable && !M_MemWrite;

  // Halfword stores only merge against a cached word; on a miss the half is mirrored.
  always_comb begin
    merged = M_Rt_data;
    if (M_SH) begin
      if (hit) merged = a_half ? {M_Rt_data[HW-1:0], rd_data[HW-1:0]}
                               : {rd_data[data_size-1:HW], M_Rt_data[HW-1:0]};
      else     merged = {2{M_Rt_data[HW-1:0]}};
    end
  end

  // Upstream holds the address stable, so the lookup index also addresses every write.
  assign data_we = mem.mem_ready && ((state_q == REFILL) || ((state_q == WRITE) && hit));
  assign tag_we  = mem.mem_ready && (state_q == REFILL) && (cnt_q == 2'd3);
  assign wr_word = (state_q == REFILL) ? cnt_q : a_word;
  assign wr_data = (state_q == REFILL) ? mem.mem_rdata : merged;

  assign lookup       = ((state_q == IDLE) || (state_q == RESP)) && is_load && hit;
  assign M_rdata      = (!rst && lookup) ? (M_LH ? half_sext(rd_data, a_half) : rd_data) : '0;
  assign dcache_stall = !rst && (((state_q == IDLE) && (M_MemWrite || (is_load && !hit))) ||
                                 (state_q == REFILL) || (state_q == WRITE));

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign dbg_state_o   = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef DCACHE_PERF_CNT_EN
      hit_cnt  <= '0;
      miss_cnt <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (M_MemWrite) begin
            state_q <= WRITE;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= {M_ALU_result[pc_size-1:2], 2'b00};
            wdata_q <= merged;
          end else if (M_Read_enable && !hit) begin
            state_q <= REFILL;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= {M_ALU_result[pc_size-1:4], 4'b0000};
`ifdef DCACHE_PERF_CNT_EN
            miss_cnt <= miss_cnt + 32'd1;
`endif
          end else if (M_Read_enable) begin
`ifdef DCACHE_PERF_CNT_EN
            hit_cnt <= hit_cnt + 32'd1;
`endif
          end
        end
        REFILL: begin
          if (mem.mem_ready) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              state_q <= RESP;
              req_q   <= 1'b0;
              addr_q  <= '0;
            end else begin
              addr_q <= {M_ALU_result[pc_size-1:4], cnt_q + 2'd1, 2'b00};
            end
          end
        end
        WRITE: begin
          if (mem.mem_ready) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_stage_dcache.sv
// Directed and randomized checks of m_stage_dcache against a line-level cache/memory model.
module tb_m_stage_dcache;
  import dcache_pkg::*;

  typedef logic [50:0] beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, mw, lh, sh;
  logic [17:0] addr;
  logic [31:0] rt;
  logic [31:0] rdata;
  logic        stall;
  state_t      dbg;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  m_stage_dcache_if #(.AW(18), .DW(32)) mem ();

  m_stage_dcache dut (
    .clk           (clk),
    .rst           (rst),
    .M_Read_enable (re),
    .M_MemWrite    (mw),
    .M_LH          (lh),
    .M_SH          (sh),
    .M_ALU_result  (addr),
    .M_Rt_data     (rt),
    .M_rdata       (rdata),
    .dcache_stall  (stall),
    .mem           (mem),
    .dbg_state_o   (dbg)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt       (hit_cnt),
    .miss_cnt      (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Backing memory and scoreboard of memory beats.
  logic [31:0] mem_model [int];
  beat_t exp_q[$];
  beat_t act_q[$];
  int beat_total = 0;
  int wait_cnt = 0;

  function automatic logic [31:0] get_word(input logic [17:0] a);
    if (!mem_model.exists(int'(a))) mem_model[int'(a)] = $urandom;
    return mem_model[int'(a)];
  endfunction

  initial begin
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem.mem_ready = 1'b0;
      if (mem.mem_req && !rst) begin
        if (wait_cnt == 0) begin
          mem.mem_ready = 1'b1;
          mem.mem_rdata = mem.mem_we ? $urandom : get_word(mem.mem_addr);
          act_q.push_back({mem.mem_we, mem.mem_addr, mem.mem_we ? mem.mem_wdata : 32'h0});
          beat_total++;
          wait_cnt = $urandom_range(0, 2);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Reference cache: one entry per index.
  logic        m_valid [16];
  logic [9:0]  m_tag   [16];
  logic [31:0] m_line  [16][4];
  int          m_hits, m_misses;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic idle_inputs();
    re = 0; mw = 0; lh = 0; sh = 0; addr = '0; rt = '0;
  endtask

  task automatic finish_op(input string name);
    @(negedge clk);
    idle_inputs();
    #1;
    check({name, "_idle_stall"}, stall, 0);
    check({name, "_idle_req"}, mem.mem_req, 0);
    check({name, "_idle_rdata"}, rdata, 0);
    check({name, "_beat_count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0)
      check({name, "_beat"}, act_q.pop_front(), exp_q.pop_front());
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic do_load(input logic [17:0] a, input logic is_lh);
    int idx, w, n;
    logic hit;
    logic [31:0] word, expv;
    logic [15:0] half;
    logic [1:0] kk;
    idx = int'(a[7:4]);
    w = int'(a[3:2]);
    hit = m_valid[idx] && (m_tag[idx] == a[17:8]);
    if (!hit) begin
      for (int k = 0; k < 4; k++) begin
        kk = 2'(k);
        exp_q.push_back({1'b0, a[17:4], kk, 2'b00, 32'h0});
        m_line[idx][k] = get_word({a[17:4], kk, 2'b00});
      end
      m_valid[idx] = 1'b1;
      m_tag[idx] = a[17:8];
      m_misses++;
    end else begin
      m_hits++;
    end
    word = m_line[idx][w];
    half = a[1] ? word[31:16] : word[15:0];
    expv = is_lh ? {{16{half[15]}}, half} : word;

    @(negedge clk);
    re = 1; mw = 0; lh = is_lh; sh = 0; addr = a; rt = $urandom;
    #1;
    check("ld_stall_first", stall, !hit);
    if (hit) begin
      check("ld_hit_data", rdata, expv);
      check("ld_hit_req", mem.mem_req, 0);
    end else begin
      n = 0;
      while (stall && n < 64) begin
        @(negedge clk);
        #1;
        n++;
      end
      if (n >= 64) check("ld_timeout", 1, 0);
      check("ld_resp_state", dbg, RESP);
      check("ld_resp_data", rdata, expv);
    end
    finish_op("ld");
  endtask

  task automatic do_store(input logic [17:0] a, input logic is_sh, input logic [31:0] d,
                          input logic with_read);
    int idx, w, n;
    logic hit, held;
    logic [31:0] old, mrg;
    idx = int'(a[7:4]);
    w = int'(a[3:2]);
    hit = m_valid[idx] && (m_tag[idx] == a[17:8]);
    old = m_line[idx][w];
    if (!is_sh)   mrg = d;
    else if (hit) mrg = a[1] ? {d[15:0], old[15:0]} : {old[31:16], d[15:0]};
    else          mrg = {d[15:0], d[15:0]};
    exp_q.push_back({1'b1, a[17:2], 2'b00, mrg});
    mem_model[int'({a[17:2], 2'b00})] = mrg;
    if (hit) m_line[idx][w] = mrg;

    @(negedge clk);
    re = with_read; mw = 1; lh = 0; sh = is_sh; addr = a; rt = d;
    #1;
    check("st_stall_first", stall, 1);
    check("st_rdata_zero", rdata, 0);
    n = 0;
    held = 1'b1;
    while (!mem.mem_ready && n < 64) begin
      @(negedge clk);
      #1;
      if (!stall) held = 1'b0;
      n++;
    end
    if (n >= 64) check("st_timeout", 1, 0);
    check("st_stall_held", held, 1);
    check("st_stall_ack", stall, 1);
    finish_op("st");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [17:0] ra;
    int op;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_rdata", rdata, 0);
    check("rst_req", mem.mem_req, 0);
    check("rst_we", mem.mem_we, 0);
    check("rst_addr", mem.mem_addr, 0);
    check("rst_wdata", mem.mem_wdata, 0);
    check("rst_state", dbg, IDLE);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a refill abandons it.
    n = beat_total;
    re = 1; addr = 18'h00200;
    begin
      int t;
      t = 0;
      while (beat_total < n + 2 && t < 64) begin
        @(negedge clk);
        t++;
      end
      if (t >= 64) check("mid_refill_timeout", 1, 0);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_stall", stall, 0);
    check("midrst_rdata", rdata, 0);
    check("midrst_req", mem.mem_req, 0);
    check("midrst_addr", mem.mem_addr, 0);
    check("midrst_state", dbg, IDLE);
`ifdef DCACHE_PERF_CNT_EN
    check("midrst_miss_cnt", miss_cnt, 0);
`endif
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    act_q.delete();
    exp_q.delete();
    model_reset();
    do_load(18'h00200, 1'b0);

    // Cold line fill, hit, halfword loads and halfword store merge.
    mem_model[int'(18'h00040)] = 32'h1234ABCD;
    do_load(18'h00040, 1'b0);
    do_load(18'h00048, 1'b0);
    do_load(18'h00042, 1'b1);
    do_load(18'h00040, 1'b1);
    do_store(18'h00042, 1'b1, 32'h00005555, 1'b0);
    do_load(18'h00040, 1'b0);
    check("merge_const", m_line[4][0], 32'h5555ABCD);

    // Store miss does not allocate.
    do_store(18'h00100, 1'b0, $urandom, 1'b0);
    do_load(18'h00100, 1'b0);

    // Conflict replaces the line.
    do_load(18'h00140, 1'b0);
    do_load(18'h00040, 1'b0);

    // Read and write together: store only.
    do_store(18'h00044, 1'b0, $urandom, 1'b1);
    do_load(18'h00044, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      ra = {8'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ((op == 1 || op == 3) ? 1'($urandom_range(0, 1)) : 1'b0), 1'b0};
      case (op)
        0: do_load(ra, 1'b0);
        1: do_load(ra, 1'b1);
        2: do_store(ra, 1'b0, $urandom, 1'($urandom_range(0, 1)));
        default: do_store(ra, 1'b1, $urandom, 1'b0);
      endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
